// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: one 256-bit cache line request <-> four 64-bit memory beats.
// Optional per-direction completed-line counters are enabled with CACHELINE_ADAPTOR_STATS_EN.
`timescale 1ns/1ps
module cacheline_adaptor #(
   parameter int s_offset  = 5,
   parameter int s_line    = 8 * (2 ** s_offset),
   parameter int s_burst   = 64,
   parameter int num_beats = s_line / s_burst
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pmem_address,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic [31:0]       mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [s_burst-1:0] mem_wdata,
   input  logic [s_burst-1:0] mem_rdata,
   input  logic              mem_resp
`ifdef CACHELINE_ADAPTOR_STATS_EN
   ,output logic [31:0]      rd_lines
   ,output logic [31:0]      wr_lines
`endif
);

   localparam int cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e                            state_q, state_d;
   logic [cnt_w-1:0]                  cnt_q, cnt_d;
   logic [31:0]                       addr_q, addr_d;
   logic [num_beats-1:0][s_burst-1:0] wbuf_q, wbuf_d;
   logic [num_beats-1:0][s_burst-1:0] rbuf_q, rbuf_d;
   logic                              last_beat;
   logic                              unused_offset;

   // Offset bits never reach the memory bus; the burst always starts on a line boundary.
   assign unused_offset = ^pmem_address[s_offset-1:0];
   assign last_beat     = (cnt_q == cnt_w'(num_beats - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         IDLE: begin
            // Write wins when the cache (illegally) raises both requests.
            if (pmem_write) begin
               state_d = WRITE;
               cnt_d   = '0;
               addr_d  = {pmem_address[31:s_offset], {s_offset{1'b0}}};
               wbuf_d  = pmem_wdata;
            end else if (pmem_read) begin
               state_d = READ;
               cnt_d   = '0;
               addr_d  = {pmem_address[31:s_offset], {s_offset{1'b0}}};
            end
         end
         READ: begin
            if (mem_resp) begin
               rbuf_d[cnt_q] = mem_rdata;
               cnt_d         = cnt_q + cnt_w'(1);
               if (last_beat) state_d = DONE;
            end
         end
         WRITE: begin
            if (mem_resp) begin
               cnt_d = cnt_q + cnt_w'(1);
               if (last_beat) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_read    = (state_q == READ);
   assign mem_write   = (state_q == WRITE);
   assign pmem_resp   = (state_q == DONE);
   assign mem_address = addr_q;
   assign mem_wdata   = (state_q == WRITE) ? wbuf_q[cnt_q] : '0;
   assign pmem_rdata  = rbuf_q;

`ifdef CACHELINE_ADAPTOR_STATS_EN
   logic        op_wr_q;
   logic [31:0] rd_lines_q, wr_lines_q;

   // op_wr_q tracks the pending request kind so DONE knows which counter to bump.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_wr_q    <= 1'b0;
         rd_lines_q <= '0;
         wr_lines_q <= '0;
      end else begin
         if (state_q == IDLE) op_wr_q <= pmem_write;
         if (state_q == DONE) begin
            if (op_wr_q) begin
               if (wr_lines_q != '1) wr_lines_q <= wr_lines_q + 32'd1;
            end else begin
               if (rd_lines_q != '1) rd_lines_q <= rd_lines_q + 32'd1;
            end
         end
      end
   end

   assign rd_lines = rd_lines_q;
   assign wr_lines = wr_lines_q;
`endif

endmodule
